// File: rtl/wdq2pe_wbuf_if.sv
// Purpose: bundles the weight-row producer, matrix release and PE read ports
//          of the wdq2pe double-buffered weight buffer.
// Ports (grouped by modport):
//   slave  (buffer side): enable_i, clear_i, dq_1row_* row stream, fill_done_o,
//          wbuf_valid_o, wbuf_release_i, pe_* read port, busy_o, dup_err_o
//   master (driver side): the same signals with the directions reversed
interface wdq2pe_wbuf_if #(
    parameter int unsigned RAM_DATA_1ELM_WIDTH = 32,
    parameter int unsigned MATRIX_NUM_COL      = 16,
    parameter int unsigned MATRIX_NUM_ROW      = 16
);
    localparam int unsigned ROW_WIDTH = MATRIX_NUM_COL * RAM_DATA_1ELM_WIDTH;
    localparam int unsigned LOG_ROW   = $clog2(MATRIX_NUM_ROW);

    logic                 enable_i;
    logic                 clear_i;
    logic [ROW_WIDTH-1:0] dq_1row_data_i;
    logic [LOG_ROW-1:0]   dq_row_index_i;
    logic                 dq_1row_valid_i;
    logic                 dq_1row_ready_o;
    logic                 fill_done_o;
    logic                 wbuf_valid_o;
    logic                 wbuf_release_i;
    logic                 pe_ren_i;
    logic [LOG_ROW-1:0]   pe_rindex_i;
    logic [ROW_WIDTH-1:0] pe_rdata_o;
    logic                 pe_rvalid_o;
    logic                 busy_o;
    logic                 dup_err_o;

    modport slave (
        input  enable_i, clear_i, dq_1row_data_i, dq_row_index_i, dq_1row_valid_i,
               wbuf_release_i, pe_ren_i, pe_rindex_i,
        output dq_1row_ready_o, fill_done_o, wbuf_valid_o, pe_rdata_o, pe_rvalid_o,
               busy_o, dup_err_o
    );

    modport master (
        output enable_i, clear_i, dq_1row_data_i, dq_row_index_i, dq_1row_valid_i,
               wbuf_release_i, pe_ren_i, pe_rindex_i,
        input  dq_1row_ready_o, fill_done_o, wbuf_valid_o, pe_rdata_o, pe_rvalid_o,
               busy_o, dup_err_o
    );
endinterface

// File: rtl/wdq2pe_wbuf.sv
// Purpose: ping-pong weight buffer between the dequantizer and the PE array.
//          Rows fill the write bank in any order; once every row index has been
//          seen the bank becomes FULL and is handed to the PE side, which reads
//          rows with one cycle of latency and releases the bank when done.
// Ports:
//   clk    - sole clock, rising edge
//   rstnn  - synchronous reset, active high
//   bus    - wdq2pe_wbuf_if.slave: row stream in, fill/valid/busy/error status,
//            release input and PE row read port
module wdq2pe_wbuf #(
    parameter int unsigned RAM_DATA_1ELM_WIDTH = 32,
    parameter int unsigned MATRIX_NUM_COL      = 16,
    parameter int unsigned MATRIX_NUM_ROW      = 16
) (
    input  logic          clk,
    input  logic          rstnn,
    wdq2pe_wbuf_if.slave  bus
);
    localparam int unsigned ROW_WIDTH = MATRIX_NUM_COL * RAM_DATA_1ELM_WIDTH;
    localparam int unsigned LOG_ROW   = $clog2(MATRIX_NUM_ROW);

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_e;

    bank_state_e               state_q [2];
    bank_state_e               state_d [2];
    logic                      wr_sel_q, wr_sel_d;
    logic                      rd_sel_q, rd_sel_d;
    logic [MATRIX_NUM_ROW-1:0] mask_q, mask_d;
    logic                      fill_done_q, fill_done_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      dup_err_q, dup_err_d;
    logic                      rvalid_q, rvalid_d;
    logic [ROW_WIDTH-1:0]      rdata_q, rdata_d;

    logic [ROW_WIDTH-1:0]      mem_q [2][MATRIX_NUM_ROW];

    logic                      ready_c;
    logic                      accept_c;
    logic                      idx_ok_c;
    logic                      release_c;
    logic                      read_c;
    logic                      mem_we_c;
    logic [MATRIX_NUM_ROW-1:0] row_bit_c;
    logic [MATRIX_NUM_ROW-1:0] mask_set_c;

    // Write bank only refuses rows while it still holds an unreleased matrix.
    assign ready_c   = bus.enable_i & (state_q[wr_sel_q] != BANK_FULL);
    assign accept_c  = bus.dq_1row_valid_i & ready_c;
    // One extra bit so the range check stays meaningful for power-of-two rows.
    assign idx_ok_c  = {1'b0, bus.dq_row_index_i} < (LOG_ROW + 1)'(MATRIX_NUM_ROW);
    assign row_bit_c = MATRIX_NUM_ROW'(1) << bus.dq_row_index_i;
    assign release_c = bus.wbuf_release_i & valid_q;
    assign read_c    = bus.pe_ren_i & valid_q;

    // Next-state: PE read and release use the pre-edge read bank, accept the write bank.
    always_comb begin
        state_d     = state_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        mask_d      = mask_q;
        fill_done_d = 1'b0;
        dup_err_d   = dup_err_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        mem_we_c    = 1'b0;
        mask_set_c  = mask_q | row_bit_c;

        if (read_c) begin
            rdata_d  = mem_q[rd_sel_q][bus.pe_rindex_i];
            rvalid_d = 1'b1;
        end

        if (release_c) begin
            state_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d          = ~rd_sel_q;
        end

        if (accept_c) begin
            if (!idx_ok_c) begin
                dup_err_d = 1'b1;
            end else begin
                mem_we_c = 1'b1;
                if ((mask_q & row_bit_c) != '0) begin
                    dup_err_d = 1'b1;
                end
                if (mask_set_c == '1) begin
                    state_d[wr_sel_q] = BANK_FULL;
                    mask_d            = '0;
                    wr_sel_d          = ~wr_sel_q;
                    fill_done_d       = 1'b1;
                end else begin
                    state_d[wr_sel_q] = BANK_FILL;
                    mask_d            = mask_set_c;
                end
            end
        end

        if (bus.clear_i) begin
            state_d[0]  = BANK_EMPTY;
            state_d[1]  = BANK_EMPTY;
            wr_sel_d    = 1'b0;
            rd_sel_d    = 1'b0;
            mask_d      = '0;
            fill_done_d = 1'b0;
            dup_err_d   = 1'b0;
            rvalid_d    = 1'b0;
            rdata_d     = '0;
            mem_we_c    = 1'b0;
        end

        valid_d = (state_d[rd_sel_d] == BANK_FULL);
        busy_d  = (state_d[0] != BANK_EMPTY) | (state_d[1] != BANK_EMPTY);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rstnn) begin
            state_q[0]  <= BANK_EMPTY;
            state_q[1]  <= BANK_EMPTY;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            mask_q      <= '0;
            fill_done_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            dup_err_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            mask_q      <= mask_d;
            fill_done_q <= fill_done_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            dup_err_q   <= dup_err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Bank storage; contents are don't-care after reset, the row mask tracks validity.
    always_ff @(posedge clk) begin
        if (!rstnn && mem_we_c) begin
            mem_q[wr_sel_q][bus.dq_row_index_i] <= bus.dq_1row_data_i;
        end
    end

    assign bus.dq_1row_ready_o = ready_c;
    assign bus.fill_done_o     = fill_done_q;
    assign bus.wbuf_valid_o    = valid_q;
    assign bus.busy_o          = busy_q;
    assign bus.dup_err_o       = dup_err_q;
    assign bus.pe_rvalid_o     = rvalid_q;
    assign bus.pe_rdata_o      = rdata_q;
endmodule

// File: tb/tb_wdq2pe_wbuf.sv
module tb_wdq2pe_wbuf;
    localparam int unsigned NR = 16;
    localparam int unsigned RW = 512;
    localparam int unsigned LR = 4;

    typedef logic [NR-1:0][RW-1:0] mat_t;

    logic clk;
    logic rstnn;
    int   n_checks;
    int   n_errors;

    // Reference model: completed matrices in delivery order plus one partial fill.
    mat_t          full_q [$];
    mat_t          part;
    logic [NR-1:0] got;
    logic          m_dup;
    logic          m_fd;
    logic          m_rvalid;
    logic [RW-1:0] m_rdata;

    wdq2pe_wbuf_if intf ();

    wdq2pe_wbuf dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < int'(RW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic step(input logic en, input logic clr, input logic vld, input logic [LR-1:0] idx,
                        input logic [RW-1:0] data, input logic rel, input logic ren,
                        input logic [LR-1:0] ridx);
        logic exp_ready;
        intf.enable_i        = en;
        intf.clear_i         = clr;
        intf.dq_1row_valid_i = vld;
        intf.dq_row_index_i  = idx;
        intf.dq_1row_data_i  = data;
        intf.wbuf_release_i  = rel;
        intf.pe_ren_i        = ren;
        intf.pe_rindex_i     = ridx;
        #1;
        exp_ready = en && (full_q.size() < 2);
        check("ready", RW'(intf.dq_1row_ready_o), RW'(exp_ready));
        @(posedge clk);
        if (rstnn || clr) begin
            full_q.delete();
            got      = '0;
            m_dup    = 1'b0;
            m_fd     = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rvalid = ren && (full_q.size() > 0);
            if (m_rvalid) m_rdata = full_q[0][ridx];
            m_fd = 1'b0;
            if (rel && (full_q.size() > 0)) void'(full_q.pop_front());
            if (vld && exp_ready) begin
                if (got[idx]) m_dup = 1'b1;
                got[idx]  = 1'b1;
                part[idx] = data;
                if (&got) begin
                    full_q.push_back(part);
                    got  = '0;
                    m_fd = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("fill_done", RW'(intf.fill_done_o), RW'(m_fd));
        check("wbuf_valid", RW'(intf.wbuf_valid_o), RW'(full_q.size() > 0));
        check("busy", RW'(intf.busy_o), RW'((full_q.size() > 0) || (got != '0)));
        check("dup_err", RW'(intf.dup_err_o), RW'(m_dup));
        check("pe_rvalid", RW'(intf.pe_rvalid_o), RW'(m_rvalid));
        check("pe_rdata", intf.pe_rdata_o, m_rdata);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic [LR-1:0] idx);
        step(1'b1, 1'b0, 1'b1, idx, rnd_row(), 1'b0, 1'b0, '0);
    endtask

    task automatic read(input logic [LR-1:0] ridx);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ridx);
    endtask

    task automatic release_bank();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic clear_pulse();
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        n_checks             = 0;
        n_errors             = 0;
        got                  = '0;
        part                 = '0;
        m_dup                = 1'b0;
        m_fd                 = 1'b0;
        m_rvalid             = 1'b0;
        m_rdata              = '0;
        rstnn                = 1'b1;
        intf.enable_i        = 1'b0;
        intf.clear_i         = 1'b0;
        intf.dq_1row_valid_i = 1'b0;
        intf.dq_row_index_i  = '0;
        intf.dq_1row_data_i  = '0;
        intf.wbuf_release_i  = 1'b0;
        intf.pe_ren_i        = 1'b0;
        intf.pe_rindex_i     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        idle();
        rstnn = 1'b0;
        idle();

        // In-order fill, then read row 5
        for (int i = 0; i < int'(NR); i++) send(LR'(i));
        idle();
        read(LR'(5));
        read(LR'(0));

        // Second matrix, third row blocked, release reopens the write side
        for (int i = 0; i < int'(NR); i++) send(LR'(i));
        step(1'b1, 1'b0, 1'b1, LR'(0), rnd_row(), 1'b1, 1'b0, '0);
        send(LR'(1));
        read(LR'(7));
        // Read and release in the same cycle see the pre-release bank
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, LR'(15));
        idle();

        // Reverse order with row 3 sent twice
        clear_pulse();
        for (int i = int'(NR) - 1; i >= 3; i--) send(LR'(i));
        send(LR'(3));
        for (int i = 2; i >= 0; i--) send(LR'(i));
        read(LR'(3));
        read(LR'(4));

        // Partial fill discarded by clear, fresh fill of bank 0
        clear_pulse();
        for (int i = 0; i < 8; i++) send(LR'(i));
        clear_pulse();
        for (int i = int'(NR) - 1; i >= 0; i--) send(LR'(i));
        read(LR'(2));

        // Release of bank 0 coincides with completion of bank 1
        clear_pulse();
        for (int i = 0; i < int'(NR); i++) send(LR'(i));
        for (int i = 0; i < int'(NR) - 1; i++) send(LR'(i));
        step(1'b1, 1'b0, 1'b1, LR'(NR - 1), rnd_row(), 1'b1, 1'b0, '0);
        read(LR'(NR - 1));
        step(1'b0, 1'b0, 1'b1, LR'(0), rnd_row(), 1'b0, 1'b1, LR'(9));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 8) != 0, ($urandom % 300) == 0, ($urandom % 4) != 0,
                 LR'($urandom), rnd_row(), ($urandom % 6) == 0, ($urandom % 2) == 0,
                 LR'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
